// File: rtl/sme_pkg.sv
// Shared types and helpers for the SME preamble stitcher.
package sme_pkg;

    // Widest beat the byte-reverse helper handles; callers size-cast in and out.
    localparam int unsigned MAX_BYTES = 128;
    localparam int unsigned MAX_W     = MAX_BYTES * 8;

    // Filler byte used for missing preamble bytes and EXTRA-beat padding.
    localparam logic [7:0] PRE_FILL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        STITCH,
        EXTRA
    } stitch_state_e;

    // Reverse the low nbytes bytes of d: byte 0 moves to byte nbytes-1.
    function automatic logic [MAX_W-1:0] byte_reverse(input logic [MAX_W-1:0] d,
                                                      input int unsigned nbytes);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (i < nbytes) begin
                r[i*8 +: 8] = d[(nbytes-1-i)*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sme_preamble_table.sv
// Per-flow preamble register file: one combinational read port, one write
// port and one clear port. A clear to the slot being written wins.
module sme_preamble_table #(
    parameter int unsigned FLOW_SLOTS = 4,
    parameter int unsigned SLOT_W     = $clog2(FLOW_SLOTS),
    parameter int unsigned PRE_W      = 56
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic              rd_valid,
    output logic [PRE_W-1:0]  rd_data,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [PRE_W-1:0]  wr_data,
    input  logic              clr_en,
    input  logic [SLOT_W-1:0] clr_slot
);

    logic [FLOW_SLOTS-1:0] valid_q;
    logic [PRE_W-1:0]      pre_q [FLOW_SLOTS];

    // Slot valid bits and preamble storage; clear has priority over write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(FLOW_SLOTS); i++) begin
                pre_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(FLOW_SLOTS); i++) begin
                if (clr_en && clr_slot == SLOT_W'(i)) begin
                    valid_q[i] <= 1'b0;
                end else if (wr_en && wr_slot == SLOT_W'(i)) begin
                    valid_q[i] <= 1'b1;
                end
                if (wr_en && wr_slot == SLOT_W'(i)) begin
                    pre_q[i] <= wr_data;
                end
            end
        end
    end

    assign rd_valid = valid_q[rd_slot];
    assign rd_data  = pre_q[rd_slot];

endmodule

// File: rtl/sme_preamble_stitcher.sv
// Prepends the stored tail of a flow's previous segment to the current
// segment so cross-boundary patterns stay visible to the string matcher.
module sme_preamble_stitcher
    import sme_pkg::*;
#(
    parameter int unsigned BYTE_COUNT = 16,
    parameter int unsigned EMPTY_W    = $clog2(BYTE_COUNT),
    parameter int unsigned PRE_BYTES  = 7,
    parameter int unsigned FLOW_SLOTS = 4,
    parameter int unsigned SLOT_W     = $clog2(FLOW_SLOTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BYTE_COUNT*8-1:0] s_axis_tdata,
    input  logic [EMPTY_W-1:0]      s_axis_tempty,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    input  logic [SLOT_W-1:0]       s_flow_slot,
    input  logic                    s_flow_new,
    input  logic                    slot_clear,
    input  logic [SLOT_W-1:0]       slot_clear_id,
    output logic [BYTE_COUNT*8-1:0] m_pkt_data,
    output logic [EMPTY_W-1:0]      m_pkt_empty,
    output logic                    m_pkt_valid,
    output logic                    m_pkt_sop,
    output logic                    m_pkt_eop,
    input  logic                    m_pkt_ready,
    output logic [PRE_BYTES*8-1:0]  state_out,
    output logic [SLOT_W-1:0]       state_out_slot,
    output logic                    state_out_valid
);

    localparam int unsigned DW  = BYTE_COUNT * 8;
    localparam int unsigned PW  = PRE_BYTES * 8;
    localparam int unsigned EW1 = EMPTY_W + 1;
    localparam logic [EMPTY_W:0] PRE_E     = EW1'(PRE_BYTES);
    localparam logic [EMPTY_W:0] BC_LESS_P = EW1'(BYTE_COUNT - PRE_BYTES);

    stitch_state_e     state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [PW-1:0]     carry_q, carry_d;
    logic [EMPTY_W-1:0] tempty_q, tempty_d;
    logic [DW-1:0]     data_q, data_d;
    logic [EMPTY_W-1:0] empty_q, empty_d;
    logic              valid_q, valid_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic [PW-1:0]     so_data_q;
    logic [SLOT_W-1:0] so_slot_q;
    logic              so_valid_q;

    logic              accept;
    logic              in_fire;
    logic [DW-1:0]     rev;
    logic [SLOT_W-1:0] cur_slot;
    logic              tbl_valid;
    logic [PW-1:0]     tbl_data;
    logic              cur_stitch;
    logic [PW-1:0]     carry_cur;
    logic [PW-1:0]     prefix;
    logic [PW-1:0]     tail;
    logic [EMPTY_W:0]  tempty_ext;
    logic              wr_en;

    assign accept        = !valid_q || m_pkt_ready;
    assign s_axis_tready = accept && (state_q != EXTRA);
    assign in_fire       = s_axis_tvalid && s_axis_tready;

    // Wire byte 0 ends up in the most significant byte.
    assign rev = DW'(byte_reverse(MAX_W'(s_axis_tdata), BYTE_COUNT));

    // The table is only consulted on the first beat; later beats use carry_q,
    // so a mid-segment clear or rewrite cannot disturb the segment in flight.
    assign cur_slot   = (state_q == IDLE) ? s_flow_slot : slot_q;
    assign cur_stitch = (state_q == IDLE) ? (tbl_valid && !s_flow_new) : (state_q == STITCH);
    assign carry_cur  = (state_q == IDLE) ? tbl_data : carry_q;
    assign prefix     = cur_stitch ? carry_cur : {PRE_BYTES{PRE_FILL}};
    assign tempty_ext = {1'b0, s_axis_tempty};

    // Last PRE_BYTES valid bytes of {prefix, reversed beat}; short beats pull
    // the missing bytes from the prefix.
    assign tail = PW'({prefix, rev} >> {s_axis_tempty, 3'b000});

    sme_preamble_table #(
        .FLOW_SLOTS(FLOW_SLOTS),
        .SLOT_W    (SLOT_W),
        .PRE_W     (PW)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .rd_slot (cur_slot),
        .rd_valid(tbl_valid),
        .rd_data (tbl_data),
        .wr_en   (wr_en),
        .wr_slot (cur_slot),
        .wr_data (tail),
        .clr_en  (slot_clear),
        .clr_slot(slot_clear_id)
    );

    // Next-state, output-register and table-write decode.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        carry_d  = carry_q;
        tempty_d = tempty_q;
        data_d   = data_q;
        empty_d  = empty_q;
        valid_d  = valid_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        wr_en    = 1'b0;

        // A free or drained output register goes empty unless reloaded below.
        if (accept) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE, PASS, STITCH: begin
                if (in_fire) begin
                    valid_d = 1'b1;
                    sop_d   = (state_q == IDLE);
                    carry_d = rev[PW-1:0];
                    wr_en   = s_axis_tlast;
                    if (state_q == IDLE) begin
                        slot_d = s_flow_slot;
                    end
                    if (cur_stitch) begin
                        data_d  = {carry_cur, rev[DW-1:PW]};
                        eop_d   = 1'b0;
                        empty_d = '0;
                        state_d = STITCH;
                        if (s_axis_tlast) begin
                            if (tempty_ext >= PRE_E) begin
                                eop_d   = 1'b1;
                                empty_d = EMPTY_W'(tempty_ext - PRE_E);
                                state_d = IDLE;
                            end else begin
                                tempty_d = s_axis_tempty;
                                state_d  = EXTRA;
                            end
                        end
                    end else begin
                        data_d  = rev;
                        eop_d   = s_axis_tlast;
                        empty_d = s_axis_tlast ? s_axis_tempty : '0;
                        state_d = s_axis_tlast ? IDLE : PASS;
                    end
                end
            end
            EXTRA: begin
                // Flush the bytes pushed out of the last beat by the preamble.
                if (accept) begin
                    valid_d = 1'b1;
                    sop_d   = 1'b0;
                    eop_d   = 1'b1;
                    data_d  = {carry_q, {(DW-PW){1'b1}}};
                    empty_d = EMPTY_W'(BC_LESS_P + {1'b0, tempty_q});
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, output register and tail-report register update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            carry_q    <= '0;
            tempty_q   <= '0;
            data_q     <= '0;
            empty_q    <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            so_data_q  <= '0;
            so_slot_q  <= '0;
            so_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            carry_q    <= carry_d;
            tempty_q   <= tempty_d;
            data_q     <= data_d;
            empty_q    <= empty_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            so_valid_q <= wr_en;
            if (wr_en) begin
                so_data_q <= tail;
                so_slot_q <= cur_slot;
            end
        end
    end

    assign m_pkt_data      = data_q;
    assign m_pkt_empty     = empty_q;
    assign m_pkt_valid     = valid_q;
    assign m_pkt_sop       = sop_q;
    assign m_pkt_eop       = eop_q;
    assign state_out       = so_data_q;
    assign state_out_slot  = so_slot_q;
    assign state_out_valid = so_valid_q;

endmodule
